// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one SRAM-like memory port (fetch vs. data).
// Data wins by default; a saturating starvation counter forces a fetch grant.
//
// state | meaning
// IDLE  | no transaction outstanding, arbitrate and accept one request
// REQ   | mem_req driven with registered fields, waiting for mem_addr_ok
// RESP  | request accepted downstream, waiting for mem_data_ok
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  state_t           state, state_nxt;
  logic             owner_inst;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_inst, grant_data, done;

  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_inst = inst_req && (!data_req || starve_cnt == CNT_W'(STARVE_MAX));
        grant_data = data_req && !grant_inst;
        if (grant_inst || grant_data) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (mem_addr_ok) begin
          done      = mem_data_ok;
          state_nxt = mem_data_ok ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_data_ok) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Accept pulses are combinational from requests, so mask them while reset is held.
  assign inst_addr_ok = grant_inst & resetn;
  assign data_addr_ok = grant_data & resetn;
  assign inst_data_ok = done & owner_inst;
  assign data_data_ok = done & ~owner_inst;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      owner_inst <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_inst) begin
        owner_inst <= 1'b1;
        starve_cnt <= '0;
        mem_req    <= 1'b1;
        mem_wr     <= 1'b0;
        mem_wstrb  <= '0;
        mem_addr   <= inst_addr;
        mem_wdata  <= '0;
      end else if (grant_data) begin
        owner_inst <= 1'b0;
        if (!inst_req)
          starve_cnt <= '0;
        else if (starve_cnt != CNT_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + CNT_W'(1);
        mem_req    <= 1'b1;
        mem_wr     <= data_wr;
        mem_wstrb  <= data_wr ? data_wstrb : '0;
        mem_addr   <= data_addr;
        mem_wdata  <= data_wdata;
      end else if (state == ST_REQ && mem_addr_ok) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, write, priority, starvation,
// downstream stall and mid-transaction reset, all with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE with requests already driven; owner expected as given.
  task automatic txn(input string tag, input bit exp_inst, input bit drop, input logic [31:0] rd);
    @(negedge clk);
    chk($sformatf("%s_aok", tag), {inst_addr_ok, data_addr_ok}, exp_inst ? 2'b10 : 2'b01);
    cyc();
    if (drop) begin
      if (exp_inst) inst_req = 1'b0;
      else          data_req = 1'b0;
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_req", tag), mem_req, 1);
    chk($sformatf("%s_noaok", tag), {inst_addr_ok, data_addr_ok}, 0);
    cyc();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    @(negedge clk);
    chk($sformatf("%s_dok", tag), {inst_data_ok, data_data_ok}, exp_inst ? 2'b10 : 2'b01);
    chk($sformatf("%s_rdata", tag), exp_inst ? inst_rdata : data_rdata, rd);
    cyc();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
    chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // stray response in IDLE
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("idle_stray_dok", {inst_data_ok, data_data_ok}, 0);
    cyc();
    mem_data_ok = 1'b0;

    // 1: single fetch, T / T+1 / T+2
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    @(negedge clk);
    chk("f_aok", {inst_addr_ok, data_addr_ok}, 2'b10);
    chk("f_req_t0", mem_req, 0);
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("f_req_t1", {mem_req, mem_wr, mem_wstrb}, {1'b1, 1'b0, 4'h0});
    chk("f_addr", mem_addr, 32'h1c000000);
    chk("f_dok_t1", {inst_data_ok, data_data_ok}, 0);
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02800c0c;
    @(negedge clk);
    chk("f_dok_t2", {inst_data_ok, data_data_ok, mem_req}, 3'b100);
    chk("f_rdata", inst_rdata, 32'h02800c0c);
    cyc();
    mem_data_ok = 1'b0;

    // 2: write, addr_ok and data_ok together in REQ
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h1c008000; data_wdata = 32'hdeadbeef;
    @(negedge clk);
    chk("w_aok", {inst_addr_ok, data_addr_ok}, 2'b01);
    cyc();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    @(negedge clk);
    chk("w_ctl", {mem_req, mem_wr, mem_wstrb}, {1'b1, 1'b1, 4'b0011});
    chk("w_addr", mem_addr, 32'h1c008000);
    chk("w_wdata", mem_wdata, 32'hdeadbeef);
    cyc();
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("w_dok", {inst_data_ok, data_data_ok}, 2'b01);
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
    chk("w_idle", {mem_req, inst_data_ok, data_data_ok}, 0);
    cyc();

    // 3: simultaneous requests, data first then fetch
    inst_req = 1'b1; inst_addr = 32'h1c000004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1c008004;
    txn("p_data", 1'b0, 1'b1, 32'h11111111);
    txn("p_inst", 1'b1, 1'b1, 32'h22222222);

    // 4: both held, pattern D D D D I D D D D I
    inst_req = 1'b1; data_req = 1'b1;
    for (int i = 0; i < 10; i++)
      txn($sformatf("s%0d", i), (i == 4) || (i == 9), 1'b0, 32'h30000000 + i);
    inst_req = 1'b0; data_req = 1'b0;
    cyc();

    // 5: downstream stall on a read; wstrb must be zeroed, stray data_ok ignored
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hf;
    data_addr = 32'h1c008010; data_wdata = 32'h55aa55aa;
    @(negedge clk);
    chk("st_aok", data_addr_ok, 1);
    cyc();
    data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_data_ok = (i == 2);
      @(negedge clk);
      chk($sformatf("st%0d_req", i), {mem_req, mem_wr, mem_wstrb}, {1'b1, 1'b0, 4'h0});
      chk($sformatf("st%0d_addr", i), mem_addr, 32'h1c008010);
      chk($sformatf("st%0d_oks", i), {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      cyc();
    end
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hcafef00d;
    @(negedge clk);
    chk("st_dok", {inst_data_ok, data_data_ok}, 2'b01);
    chk("st_rdata", data_rdata, 32'hcafef00d);
    cyc();
    mem_data_ok = 1'b0;

    // 6: reset while in RESP
    inst_req = 1'b1; inst_addr = 32'h1c000040;
    @(negedge clk);
    chk("r_aok", inst_addr_ok, 1);
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("r_resp_addr", mem_addr, 32'h1c000040);
    #1 resetn = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    chk("r_async_mem", {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}, 0);
    chk("r_async_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("r_late_dok", {inst_data_ok, data_data_ok}, 0);
    cyc();
    mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1c000044;
    txn("r_recover", 1'b1, 1'b1, 32'h44444444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
